// File: rtl/lcd_spi_serializer_pkg.sv
// Shared definitions for the ST7789V3 SPI transmit path: serializer state
// encodings, default SCLK divider and DC pin encodings.
package lcd_spi_serializer_pkg;

  typedef enum logic [2:0] {
    LCD_SER_IDLE  = 3'd0,
    LCD_SER_SETUP = 3'd1,
    LCD_SER_SHIFT = 3'd2,
    LCD_SER_END   = 3'd3,
    LCD_SER_GAP   = 3'd4
  } lcd_ser_state_e;

  localparam int LCD_SPI_CLK_DIV = 2;

  localparam logic LCD_DC_CMD  = 1'b0;
  localparam logic LCD_DC_DATA = 1'b1;

endpackage

// File: rtl/lcd_spi_serializer_clk_tick.sv
// Half-period tick generator: reload to div-1 on load, count down, tick at zero.
// Shared by the SPI serializer and the command decoder's delay logic.
module lcd_clk_tick (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] div,
  output logic       tick
);

  logic [7:0] ctr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctr_q <= '0;
    end else if (load) begin
      ctr_q <= div - 8'd1;
    end else if (ctr_q != 8'd0) begin
      ctr_q <= ctr_q - 8'd1;
    end
  end

  assign tick = (ctr_q == 8'd0);

endmodule

// File: rtl/lcd_spi_serializer.sv
// ST7789V3 SPI mode-0 transmitter: pops {dc, byte} packets and shifts them out MSB first.
// Define LCD_SER_CS_HOLD_EN to keep CS low across back-to-back packets.
module lcd_spi_serializer
  import lcd_spi_serializer_pkg::*;
#(
  parameter int WORD_WIDTH   = 8,
  parameter int PACKET_WIDTH = 9,
  parameter int CLK_DIV      = LCD_SPI_CLK_DIV,
  parameter int CS_GAP       = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid,
  input  logic [PACKET_WIDTH-1:0] data,
  output logic                    ready,
  output logic                    busy,
  output logic                    lcd_sclk,
  output logic                    lcd_mosi,
  output logic                    lcd_dc,
  output logic                    lcd_cs
);

  localparam int BIT_W = $clog2(WORD_WIDTH) + 1;

  lcd_ser_state_e          state_q, state_d;
  logic [WORD_WIDTH-1:0]   shreg_q, shreg_d;
  logic                    dc_q, dc_d;
  logic                    sclk_q, sclk_d;
  logic                    cs_q, cs_d;
  logic [BIT_W-1:0]        bit_ctr_q, bit_ctr_d;
  logic [3:0]              gap_ctr_q, gap_ctr_d;
  logic                    tick;
  logic                    div_load;
  logic                    ready_c;

  // Holding the divider loaded while idle makes SETUP start a full half-period.
  assign div_load = (state_q == LCD_SER_IDLE) || tick;

  lcd_clk_tick u_tick (
    .clk  (clk),
    .rst  (rst),
    .load (div_load),
    .div  (8'(CLK_DIV)),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    dc_d      = dc_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    bit_ctr_d = bit_ctr_q;
    gap_ctr_d = gap_ctr_q;
    ready_c   = 1'b0;

    unique case (state_q)
      LCD_SER_IDLE: begin
        ready_c = 1'b1;
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
        if (valid) begin
          shreg_d = data[WORD_WIDTH-1:0];
          dc_d    = data[PACKET_WIDTH-1];
          cs_d    = 1'b0;
          state_d = LCD_SER_SETUP;
        end
      end

      LCD_SER_SETUP: begin
        cs_d   = 1'b0;
        sclk_d = 1'b0;
        if (tick) begin
          bit_ctr_d = '0;
          state_d   = LCD_SER_SHIFT;
        end
      end

      LCD_SER_SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_ctr_q == BIT_W'(WORD_WIDTH - 1)) begin
              state_d = LCD_SER_END;
            end else begin
              shreg_d   = {shreg_q[WORD_WIDTH-2:0], 1'b0};
              bit_ctr_d = bit_ctr_q + BIT_W'(1);
            end
          end
        end
      end

      LCD_SER_END: begin
        sclk_d = 1'b0;
`ifdef LCD_SER_CS_HOLD_EN
        // Offer ready only on the closing tick so an accepted packet is never dropped.
        ready_c = tick;
        if (tick && valid) begin
          shreg_d = data[WORD_WIDTH-1:0];
          dc_d    = data[PACKET_WIDTH-1];
          state_d = LCD_SER_SETUP;
        end else if (tick) begin
          cs_d      = 1'b1;
          gap_ctr_d = 4'(CS_GAP - 1);
          state_d   = LCD_SER_GAP;
        end
`else
        if (tick) begin
          cs_d      = 1'b1;
          gap_ctr_d = 4'(CS_GAP - 1);
          state_d   = LCD_SER_GAP;
        end
`endif
      end

      LCD_SER_GAP: begin
        cs_d   = 1'b1;
        sclk_d = 1'b0;
        if (tick) begin
          if (gap_ctr_q == 4'd0) begin
            state_d = LCD_SER_IDLE;
          end else begin
            gap_ctr_d = gap_ctr_q - 4'd1;
          end
        end
      end

      default: begin
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
        state_d = LCD_SER_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= LCD_SER_IDLE;
      shreg_q   <= '0;
      dc_q      <= LCD_DC_CMD;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      bit_ctr_q <= '0;
      gap_ctr_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      dc_q      <= dc_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      bit_ctr_q <= bit_ctr_d;
      gap_ctr_q <= gap_ctr_d;
    end
  end

  assign ready    = ready_c && rst;
  assign busy     = (state_q != LCD_SER_IDLE);
  assign lcd_sclk = sclk_q;
  assign lcd_mosi = shreg_q[WORD_WIDTH-1];
  assign lcd_dc   = dc_q;
  assign lcd_cs   = cs_q;

endmodule

// File: tb/tb_lcd_spi_serializer.sv
// Self-checking bench for lcd_spi_serializer (CLK_DIV=2 and CLK_DIV=1 instances).
module tb_lcd_spi_serializer;

  localparam int W      = 8;
  localparam int P      = 9;
  localparam int CD     = 2;
  localparam int CG     = 1;
  localparam int TLEN   = (2*W + 2) * CD;
  localparam int PERIOD = (2*W + 2 + CG) * CD + 1;
`ifdef LCD_SER_CS_HOLD_EN
  localparam int CONT   = TLEN;
`else
  localparam int CONT   = PERIOD;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         valid_a = 1'b0, valid_b = 1'b0;
  logic [P-1:0] data_a = '0, data_b = '0;
  logic ready_a, busy_a, sclk_a, mosi_a, dc_a, cs_a;
  logic ready_b, busy_b, sclk_b, mosi_b, dc_b, cs_b;

  lcd_spi_serializer #(.WORD_WIDTH(W), .PACKET_WIDTH(P), .CLK_DIV(CD), .CS_GAP(CG)) dut_a (
    .clk(clk), .rst(rst), .valid(valid_a), .data(data_a), .ready(ready_a), .busy(busy_a),
    .lcd_sclk(sclk_a), .lcd_mosi(mosi_a), .lcd_dc(dc_a), .lcd_cs(cs_a));

  lcd_spi_serializer #(.WORD_WIDTH(W), .PACKET_WIDTH(P), .CLK_DIV(1), .CS_GAP(CG)) dut_b (
    .clk(clk), .rst(rst), .valid(valid_b), .data(data_b), .ready(ready_b), .busy(busy_b),
    .lcd_sclk(sclk_b), .lcd_mosi(mosi_b), .lcd_dc(dc_b), .lcd_cs(cs_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  int busy_cnt = 0;

  typedef struct { int fall; int rise; int len; } frame_t;
  frame_t fq[$];
  bit     bq[$];
  bit     dq[$];

  typedef struct { logic [P-1:0] pkt; logic exp_dc; logic [7:0] exp_bits; } vec_t;
  vec_t tbl[4];

  // Slave-side view of dut_a: bits captured at SCLK rising edges, CS frames.
  initial begin : mon
    frame_t cur;
    bit sp, cp;
    sp = 1'b0; cp = 1'b1;
    cur = '{0, 0, 0};
    forever begin
      @(negedge clk);
      if (busy_a === 1'b1) busy_cnt++;
      if (cp && cs_a === 1'b0) begin cur.fall = cyc; cur.len = 0; end
      if (cs_a === 1'b0) cur.len++;
      if (cs_a === 1'b0 && sclk_a === 1'b1 && !sp) begin
        bq.push_back(mosi_a);
        dq.push_back(dc_a);
      end
      if (!cp && cs_a === 1'b1) begin cur.rise = cyc; fq.push_back(cur); end
      sp = (sclk_a === 1'b1);
      cp = (cs_a !== 1'b0);
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (ready_a === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic send_a(input logic [P-1:0] p, output int acc);
    bit ok;
    wait_ready(ok);
    if (!ok) begin
      chk("send_ready_timeout", 0, 1);
      acc = -1;
    end else begin
      valid_a = 1'b1;
      data_a  = p;
      @(posedge clk);
      #1;
      acc      = cyc;
      busy_cnt = 0;
      valid_a  = 1'b0;
      data_a   = P'($urandom);
    end
  endtask

  task automatic wait_frame(output frame_t f, output bit ok);
    ok = 1'b0;
    f  = '{0, 0, 0};
    for (int n = 0; n < 300; n++) begin
      if (fq.size() > 0) begin f = fq.pop_front(); ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic pop_byte(output logic [7:0] b, output logic [7:0] d, output int n);
    b = '0; d = '0; n = 0;
    while (bq.size() > 0 && n < 8) begin
      b = {b[6:0], bq.pop_front()};
      d = {d[6:0], dq.pop_front()};
      n++;
    end
  endtask

  initial begin : main
    int acc, a1, a2, nb;
    bit ok;
    frame_t f, f2;
    logic [7:0] b, d;
    logic [P-1:0] pk[20];
    int g[20];
    int accs[20];
    int exp_frames, len_sum, exp_sp;

    tbl[0] = '{9'h02A, 1'b0, 8'b0010_1010};
    tbl[1] = '{9'h1F0, 1'b1, 8'b1111_0000};
    tbl[2] = '{9'h155, 1'b1, 8'b0101_0101};
    tbl[3] = '{9'h080, 1'b0, 8'b1000_0000};

    repeat (3) @(negedge clk);
    chk("rst_cs",    cs_a,    1);
    chk("rst_sclk",  sclk_a,  0);
    chk("rst_mosi",  mosi_a,  0);
    chk("rst_dc",    dc_a,    0);
    chk("rst_busy",  busy_a,  0);
    chk("rst_ready", ready_a, 0);
    chk("rst_cs_b",  cs_b,    1);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ready", ready_a, 1);

    for (int i = 0; i < 4; i++) begin
      send_a(tbl[i].pkt, acc);
      wait_frame(f, ok);
      chk($sformatf("tbl%0d_frame_seen", i), ok, 1);
      if (ok) begin
        chk($sformatf("tbl%0d_cs_low_len", i), f.len, TLEN);
        chk($sformatf("tbl%0d_cs_fall_lat", i), f.fall - acc, 0);
        pop_byte(b, d, nb);
        chk($sformatf("tbl%0d_nbits", i), nb, 8);
        chk($sformatf("tbl%0d_mosi", i), b, tbl[i].exp_bits);
        chk($sformatf("tbl%0d_dc", i), d, {8{tbl[i].exp_dc}});
        wait_ready(ok);
        chk($sformatf("tbl%0d_ready_lat", i), ok ? cyc - f.fall : -1, TLEN + CG*CD);
        chk($sformatf("tbl%0d_busy_len", i), busy_cnt, TLEN + CG*CD);
      end
    end

    // Two packets offered with valid held high throughout.
    wait_ready(ok);
    valid_a = 1'b1;
    data_a  = 9'h011;
    @(posedge clk);
    #1 a1 = cyc;
    data_a = 9'h1AA;
    wait_ready(ok);
    chk("b2b_second_ready", ok, 1);
    @(posedge clk);
    #1 a2 = cyc;
    valid_a = 1'b0;
    chk("b2b_accept_spacing", a2 - a1, CONT);
    wait_frame(f, ok);
    chk("b2b_frame1_seen", ok, 1);
`ifdef LCD_SER_CS_HOLD_EN
    chk("b2b_single_frame_len", f.len, 2*TLEN);
    chk("b2b_cs_rise", f.rise - a1, 2*TLEN);
    chk("b2b_rising_edges", bq.size(), 16);
`else
    wait_frame(f2, ok);
    chk("b2b_frame2_seen", ok, 1);
    chk("b2b_cs_high_between", f2.fall - f.rise, CG*CD + 1);
    chk("b2b_second_cs_rise", f2.rise - a1, PERIOD + TLEN);
`endif
    pop_byte(b, d, nb);
    chk("b2b_byte1", b, 8'h11);
    chk("b2b_dc1", d, 8'h00);
    pop_byte(b, d, nb);
    chk("b2b_byte2", b, 8'hAA);
    chk("b2b_dc2", d, 8'hFF);
    wait_ready(ok);
    repeat (4) @(negedge clk);
    chk("b2b_no_extra_frames", fq.size(), 0);

    // CLK_DIV=1 instance: SCLK toggles every cycle.
    @(negedge clk);
    chk("div1_ready", ready_b, 1);
    valid_b = 1'b1;
    data_b  = 9'h0FF;
    @(posedge clk);
    #1 valid_b = 1'b0;
    begin
      int cs_low, cs_edges, tog, run, max_run, rises, ones;
      logic sp, cp;
      cs_low = 0; cs_edges = 0; tog = 0; run = 0; max_run = 0; rises = 0; ones = 0;
      sp = 1'b0; cp = 1'b1;
      for (int n = 0; n < 30; n++) begin
        @(negedge clk);
        if (!cs_b) cs_low++;
        if (cs_b != cp) cs_edges++;
        if (sclk_b != sp) begin tog++; run++; end else run = 0;
        if (run > max_run) max_run = run;
        if (sclk_b && !sp) begin rises++; if (mosi_b) ones++; end
        sp = sclk_b; cp = cs_b;
      end
      chk("div1_cs_low", cs_low, 2*W + 2);
      chk("div1_cs_edges", cs_edges, 2);
      chk("div1_sclk_toggles", tog, 2*W);
      chk("div1_toggle_run", max_run, 2*W);
      chk("div1_rising", rises, W);
      chk("div1_mosi_ones", ones, W);
      chk("div1_dc", dc_b, 0);
    end

    // Reset during the fourth bit.
    send_a(9'h1C3, acc);
    repeat (17) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_cs", cs_a, 1);
    chk("abort_sclk", sclk_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_ready", ready_a, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_bits_sent", bq.size(), 4);
    chk("abort_ready_after", ready_a, 1);
    bq.delete(); dq.delete(); fq.delete();
    send_a(9'h029, acc);
    wait_frame(f, ok);
    chk("post_abort_frame_seen", ok, 1);
    chk("post_abort_len", f.len, TLEN);
    pop_byte(b, d, nb);
    chk("post_abort_mosi", b, 8'h29);
    chk("post_abort_dc", d, 8'h00);
    wait_ready(ok);

    // Randomized stream against the behavioural model.
    bq.delete(); dq.delete(); fq.delete();
    for (int i = 0; i < 20; i++) begin
      pk[i] = P'($urandom_range(0, 511));
      g[i]  = ($urandom_range(0, 2) == 0) ? 45 : 0;
      if (i > 0) repeat (g[i]) @(negedge clk);
      send_a(pk[i], accs[i]);
    end
    wait_ready(ok);
    repeat (4) @(negedge clk);
    exp_frames = 20;
`ifdef LCD_SER_CS_HOLD_EN
    exp_frames = 1;
    for (int i = 1; i < 20; i++) if (g[i] != 0) exp_frames++;
`endif
    chk("rnd_frames", fq.size(), exp_frames);
    len_sum = 0;
    foreach (fq[k]) len_sum += fq[k].len;
    chk("rnd_cs_low_total", len_sum, 20 * TLEN);
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin
        exp_sp = (g[i] == 0) ? CONT : ((g[i] + 1 > PERIOD) ? g[i] + 1 : PERIOD);
        chk($sformatf("rnd%0d_spacing", i), accs[i] - accs[i-1], exp_sp);
      end
      pop_byte(b, d, nb);
      chk($sformatf("rnd%0d_byte", i), b, int'(pk[i]) % 256);
      chk($sformatf("rnd%0d_dc", i), d, (int'(pk[i]) / 256) * 255);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
